logical_tile_io_bank: RTL and testbench

Parametrised multi-channel I/O logical tile: NUM_IO bidirectional pad channels sharing one configuration chain segment. Configuration is shifted into a shadow register and committed atomically on a load strobe, so the active pad configuration never glitches during shifting. Each channel has a direction bit and a polarity-invert bit. The block sits between the grid I/O routing (io_outpad/io_inpad) and the SoC pad interface, and is chained with other tiles through ccff_head/ccff_tail.

---
 rtl/logical_tile_io_bank.sv | 96 +++++++++
 tb/tb_logical_tile_io_bank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logical_tile_io_bank.sv
// Multi-channel I/O logical tile: shadow config chain with atomic commit,
// per-channel direction/polarity and active-low isolation to the SoC pads.
module logical_tile_io_bank #(
    parameter int NUM_IO = 4
) (
    input  logic              prog_clk,
    input  logic              pReset_N,
    input  logic              IO_ISOL_N,
    input  logic              ccff_head,
    input  logic              ccff_en,
    input  logic              ccff_load,
    output logic              ccff_tail,
    input  logic [NUM_IO-1:0] io_outpad,
    output logic [NUM_IO-1:0] io_inpad,
    input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
    output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
    output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
    output logic              cfg_valid,
    output logic              cfg_err
);

    localparam int CFG_W = 2 * NUM_IO;
    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // Reset state: every channel an input ({inv,dir} = 01), no inversion
    localparam logic [CFG_W-1:0] ACT_RST = {NUM_IO{2'b01}};

    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        err_d    = err_q;
        if (ccff_en) begin
            shadow_d = {shadow_q[CFG_W-2:0], ccff_head};
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            // A load overlapping a shift is always rejected
            if (ccff_load) begin
                err_d = 1'b1;
            end
        end else if (ccff_load) begin
            cnt_d = '0;
            if (cnt_q == CNT_FULL) begin
                active_d = shadow_q;
                valid_d  = 1'b1;
                err_d    = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset_N) begin
            shadow_q <= '0;
            active_q <= ACT_RST;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_IO; i++) begin
            gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[i] =
                ~IO_ISOL_N | active_q[2*i];
            gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[i] =
                (IO_ISOL_N & ~active_q[2*i])
                ? (io_outpad[i] ^ active_q[2*i+1]) : 1'b0;
            io_inpad[i] =
                (IO_ISOL_N & active_q[2*i])
                ? (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[i] ^ active_q[2*i+1])
                : 1'b0;
        end
    end

    assign ccff_tail = shadow_q[CFG_W-1];
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_logical_tile_io_bank.sv
// Directed bench for logical_tile_io_bank with an expected-value queue
// filled as stimulus is driven and drained as outputs are sampled.
module tb_logical_tile_io_bank;

    logic       prog_clk;
    logic       pReset_N;
    logic       IO_ISOL_N;
    logic       ccff_head;
    logic       ccff_en;
    logic       ccff_load;
    logic       ccff_tail;
    logic [3:0] io_outpad;
    logic [3:0] io_inpad;
    logic [3:0] soc_in;
    logic [3:0] soc_out;
    logic [3:0] soc_dir;
    logic       cfg_valid;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    logic tq[$];

    logical_tile_io_bank #(.NUM_IO(4)) dut (
        .prog_clk                        (prog_clk),
        .pReset_N                        (pReset_N),
        .IO_ISOL_N                       (IO_ISOL_N),
        .ccff_head                       (ccff_head),
        .ccff_en                         (ccff_en),
        .ccff_load                       (ccff_load),
        .ccff_tail                       (ccff_tail),
        .io_outpad                       (io_outpad),
        .io_inpad                        (io_inpad),
        .gfpga_pad_EMBEDDED_IO_HD_SOC_IN (soc_in),
        .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT(soc_out),
        .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR(soc_dir),
        .cfg_valid                       (cfg_valid),
        .cfg_err                         (cfg_err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: got %0h expected a queued value", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift(input logic b, input logic ld);
        ccff_head = b;
        ccff_en   = 1'b1;
        ccff_load = ld;
        tick();
        ccff_en   = 1'b0;
        ccff_load = 1'b0;
    endtask

    task automatic shift_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) shift(w[i], 1'b0);
    endtask

    task automatic load();
        ccff_load = 1'b1;
        tick();
        ccff_load = 1'b0;
    endtask

    initial begin
        logic [15:0] pat;
        logic        last;
        pat       = 16'b1011001011100100;
        last      = 1'b0;
        pReset_N  = 1'b0;
        IO_ISOL_N = 1'b1;
        ccff_head = 1'b0;
        ccff_en   = 1'b0;
        ccff_load = 1'b0;
        io_outpad = 4'b0000;
        soc_in    = 4'b0000;

        // Reset values
        expect_v("rst_dir", 4'b1111);
        expect_v("rst_out", 4'b0000);
        expect_v("rst_valid", 1'b0);
        expect_v("rst_err", 1'b0);
        expect_v("rst_tail", 1'b0);
        tick();
        tick();
        chk(soc_dir);
        chk(soc_out);
        chk(cfg_valid);
        chk(cfg_err);
        chk(ccff_tail);
        pReset_N = 1'b1;
        soc_in   = 4'b1010;
        expect_v("rst_inpad", 4'b1010);
        #1;
        chk(io_inpad);

        // Full config: ch3 out+inv, ch2 out, ch1 in+inv, ch0 in
        shift_word(8'b10_00_11_01);
        expect_v("cfgA_valid", 1'b1);
        expect_v("cfgA_err", 1'b0);
        expect_v("cfgA_dir", 4'b0011);
        load();
        chk(cfg_valid);
        chk(cfg_err);
        chk(soc_dir);
        io_outpad = 4'b1100;
        expect_v("cfgA_out", 4'b0100);
        #1;
        chk(soc_out);
        soc_in = 4'b0011;
        expect_v("cfgA_inpad", 4'b0001);
        #1;
        chk(io_inpad);

        // Short shift rejected, active held
        for (int i = 0; i < 5; i++) shift(1'b1, 1'b0);
        expect_v("short_err", 1'b1);
        expect_v("short_valid", 1'b1);
        expect_v("short_dir", 4'b0011);
        expect_v("short_out", 4'b0100);
        load();
        chk(cfg_err);
        chk(cfg_valid);
        chk(soc_dir);
        chk(soc_out);
        // Counter must have cleared: 3 more bits do not complete a word
        for (int i = 0; i < 3; i++) shift(1'b1, 1'b0);
        expect_v("clr_err", 1'b1);
        expect_v("clr_dir", 4'b0011);
        load();
        chk(cfg_err);
        chk(soc_dir);
        shift_word(8'b00_00_00_00);
        expect_v("cfgB_err", 1'b0);
        expect_v("cfgB_dir", 4'b0000);
        expect_v("cfgB_out", 4'b1100);
        expect_v("cfgB_inpad", 4'b0000);
        load();
        chk(cfg_err);
        chk(soc_dir);
        chk(soc_out);
        chk(io_inpad);

        // Load overlapping the 8th shift is rejected
        for (int i = 0; i < 7; i++) shift(1'b1, 1'b0);
        expect_v("sim_err", 1'b1);
        expect_v("sim_dir", 4'b0000);
        shift(1'b1, 1'b1);
        chk(cfg_err);
        chk(soc_dir);
        expect_v("cfgC_err", 1'b0);
        expect_v("cfgC_dir", 4'b1111);
        expect_v("cfgC_inpad", 4'b1100);
        load();
        chk(cfg_err);
        chk(soc_dir);
        chk(io_inpad);

        // Chain pass-through with one idle edge
        for (int k = 0; k < 16; k++) begin
            shift(pat[15-k], 1'b0);
            tq.push_back(pat[15-k]);
            if (tq.size() == 8) begin
                last = tq.pop_front();
                expect_v("tail", last);
                chk(ccff_tail);
            end
            if (k == 10) begin
                expect_v("tail_hold", last);
                tick();
                chk(ccff_tail);
            end
        end
        expect_v("chain_dir", 4'b1111);
        expect_v("chain_inpad", 4'b1100);
        #1;
        chk(soc_dir);
        chk(io_inpad);

        // Overlong shift commits the last 8 bits: 11_10_01_00
        io_outpad = 4'b0001;
        expect_v("cfgD_err", 1'b0);
        expect_v("cfgD_dir", 4'b1010);
        expect_v("cfgD_out", 4'b0101);
        expect_v("cfgD_inpad", 4'b1010);
        load();
        chk(cfg_err);
        chk(soc_dir);
        chk(soc_out);
        chk(io_inpad);

        // Isolation
        IO_ISOL_N = 1'b0;
        expect_v("iso_dir", 4'b1111);
        expect_v("iso_out", 4'b0000);
        expect_v("iso_inpad", 4'b0000);
        #1;
        chk(soc_dir);
        chk(soc_out);
        chk(io_inpad);
        IO_ISOL_N = 1'b1;

        // Reset mid-shift, reset wins over en/load
        for (int i = 0; i < 3; i++) shift(1'b1, 1'b0);
        pReset_N  = 1'b0;
        ccff_en   = 1'b1;
        ccff_load = 1'b1;
        ccff_head = 1'b1;
        expect_v("mrst_dir", 4'b1111);
        expect_v("mrst_out", 4'b0000);
        expect_v("mrst_valid", 1'b0);
        expect_v("mrst_err", 1'b0);
        expect_v("mrst_tail", 1'b0);
        expect_v("mrst_inpad", 4'b0011);
        tick();
        chk(soc_dir);
        chk(soc_out);
        chk(cfg_valid);
        chk(cfg_err);
        chk(ccff_tail);
        chk(io_inpad);
        ccff_en   = 1'b0;
        ccff_load = 1'b0;
        pReset_N  = 1'b1;
        for (int i = 0; i < 5; i++) shift(1'b1, 1'b0);
        expect_v("post_tail", 1'b0);
        expect_v("post_err", 1'b1);
        expect_v("post_valid", 1'b0);
        expect_v("post_dir", 4'b1111);
        chk(ccff_tail);
        load();
        chk(cfg_err);
        chk(cfg_valid);
        chk(soc_dir);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
